nibble_demux_assembler: RTL and testbench
=========================================

// Module: nibble_demux_assembler
// PURPOSE
//  Receive end of the 2:1 nibble mux path. A 4-bit bus carries two nibbles,
//  one at a time; a select bit tags each nibble as half 0 (low) or half 1 (high).
//  This block steers each tagged nibble into its own register.
//  It rebuilds an 8-bit word from a low nibble followed by a high nibble, and
//  pulses valid when the word is complete. Used to rebuild note/control bytes
//  after they cross a 4-bit link.
// PARAMETERS
//  TIMEOUT  1023  idle cycles allowed between the low and high nibble before abort (>=2)
//  CNT_W    10    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  in_valid    in   1  nibble on 'in' is presented this cycle
//  s           in   1  half tag: 0 = low nibble (half 0), 1 = high nibble (half 1)
//  in          in   4  nibble data
//  out0        out  4  last accepted low nibble (registered)
//  out1        out  4  last accepted high nibble (registered)
//  byte_out    out  8  {high,low} of last completed pair; holds until next completion
//  byte_valid  out  1  1-cycle pulse: byte_out updated this cycle
//  err         out  1  1-cycle pulse: protocol error or timeout
//  busy        out  1  1 while in HAVE_LO (low nibble held, high nibble awaited)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, overrides all other inputs):
//   - all outputs go to 0; state goes to IDLE; timer goes to 0.
//  States: IDLE, HAVE_LO. busy = (state==HAVE_LO), registered.
//  All outputs are registered; byte_valid/err default to 0 each cycle.
//  IDLE:
//   - in_valid & s=0: out0<=in, timer<=0, go to HAVE_LO.
//   - in_valid & s=1: nibble discarded (out1 unchanged), err<=1, stay in IDLE.
//   - no in_valid: no change.
//  HAVE_LO:
//   - in_valid & s=1: out1<=in, byte_out<={in,out0}, byte_valid<=1, go to IDLE.
//   - in_valid & s=0: out0<=in (new low replaces old), err<=1, timer<=0,
//     stay in HAVE_LO.
//   - no in_valid: timer<=timer+1. If timer==TIMEOUT-1: err<=1, go to IDLE,
//     timer<=0. out0 is kept, byte_out is unchanged.
//  Latency: byte_valid and byte_out appear on the edge that samples the high nibble,
//   so they are visible the cycle after it is presented.
//  Back-to-back: a low nibble in the cycle right after completion is accepted
//   (state is already IDLE).
//  Simultaneous timeout and in_valid: in_valid wins; the timeout branch is not taken.
//  Timer saturates structurally: it never counts in IDLE and never exceeds TIMEOUT-1.
//  rst mid-pair: the partial pair is dropped and no err is pulsed.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0, busy=0, no pulses.
//  2 Pair: (s=0,in=4'hA) then (s=1,in=4'h5) -> out0=A, out1=5, byte_out=8'h5A,
//    byte_valid high exactly 1 cycle, busy 1 for exactly 1 cycle.
//  3 Orphan high: in IDLE, (s=1,in=4'h3) -> err 1 cycle, out1 stays 0, byte_valid=0.
//  4 Double low: (s=0,1) then (s=0,2) then (s=1,F) -> err once on 2nd nibble,
//    then byte_out=8'hF2.
//  5 Timeout with TIMEOUT=4: (s=0,7), then no valid -> err on 4th idle cycle,
//    busy drops; a later (s=1,..) -> err, byte_valid=0.
//  6 Streaming pairs 11,22,33 with no gaps -> three byte_valid pulses, no err;
//    rst asserted between nibbles of the 2nd pair -> that pair is lost, no err.

Source files
------------

// File: rtl/nibble_demux_assembler_if.sv
// Nibble link bundle: tagged 4-bit input side plus the reassembled outputs.
// The master drives nibbles and the slave (assembler) drives results.
interface nibble_demux_assembler_if;
  logic       in_valid;
  logic       s;
  logic [3:0] in;
  logic [3:0] out0;
  logic [3:0] out1;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       err;
  logic       busy;

  modport master (
    output in_valid, s, in,
    input  out0, out1, byte_out, byte_valid, err, busy
  );

  modport slave (
    input  in_valid, s, in,
    output out0, out1, byte_out, byte_valid, err, busy
  );
endinterface

// File: rtl/nibble_demux_assembler.sv
// Rebuilds a byte from a tagged low nibble followed by a high nibble on a 4-bit link,
// flagging orphan highs, repeated lows and an over-long gap between the halves.
module nibble_demux_assembler #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input logic                        clk,
  input logic                        rst,
  nibble_demux_assembler_if.slave    bus
);

  typedef enum logic {IDLE = 1'b0, HAVE_LO = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [3:0]       out0_nxt, out1_nxt;
  logic [7:0]       byte_nxt;
  logic             bv_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && !bus.s) state_nxt = HAVE_LO;
      end
      HAVE_LO: begin
        if (bus.in_valid) begin
          if (bus.s) state_nxt = IDLE;
        end else if (timer == TMAX) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A presented nibble always takes priority over the timeout check.
  always_comb begin
    timer_nxt = timer;
    out0_nxt  = bus.out0;
    out1_nxt  = bus.out1;
    byte_nxt  = bus.byte_out;
    bv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!bus.s) begin
            out0_nxt  = bus.in;
            timer_nxt = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      HAVE_LO: begin
        if (bus.in_valid) begin
          if (bus.s) begin
            out1_nxt = bus.in;
            byte_nxt = {bus.in, bus.out0};
            bv_nxt   = 1'b1;
          end else begin
            out0_nxt  = bus.in;
            err_nxt   = 1'b1;
            timer_nxt = '0;
          end
        end else if (timer == TMAX) begin
          err_nxt   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      default: timer_nxt = '0;
    endcase
  end

  // Output and timer stage: everything visible to the link is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer          <= '0;
      bus.out0       <= '0;
      bus.out1       <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      timer          <= timer_nxt;
      bus.out0       <= out0_nxt;
      bus.out1       <= out1_nxt;
      bus.byte_out   <= byte_nxt;
      bus.byte_valid <= bv_nxt;
      bus.err        <= err_nxt;
      bus.busy       <= (state_nxt == HAVE_LO);
    end
  end

endmodule

// File: tb/tb_nibble_demux_assembler.sv
// Bench for nibble_demux_assembler (TIMEOUT=4): scenario tasks with inline checks,
// completed bytes checked against a queue of expected words by a negedge monitor.
module tb_nibble_demux_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   bv_count = 0;
  logic [7:0] exp_q[$];

  nibble_demux_assembler_if ifc();

  nibble_demux_assembler #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (ifc.byte_valid === 1'b1) begin
      bv_count++;
      tests++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected byte_out=%h with empty queue", ifc.byte_out);
        fails++;
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ifc.byte_out !== e) begin
          $display("FAIL sb_byte got=%h want=%h", ifc.byte_out, e);
          fails++;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic sv, input logic [3:0] d);
    ifc.in_valid = v;
    ifc.s        = sv;
    ifc.in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 4'hF);
    cyc(1'b1, 1'b1, 4'hE);
    tests++; if (ifc.out0 !== 4'h0) begin $display("FAIL reset_out0 got=%h want=0", ifc.out0); fails++; end
    tests++; if (ifc.out1 !== 4'h0) begin $display("FAIL reset_out1 got=%h want=0", ifc.out1); fails++; end
    tests++; if (ifc.byte_out !== 8'h00) begin $display("FAIL reset_byte got=%h want=00", ifc.byte_out); fails++; end
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL reset_bv got=%b want=0", ifc.byte_valid); fails++; end
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL reset_err got=%b want=0", ifc.err); fails++; end
    tests++; if (ifc.busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", ifc.busy); fails++; end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_orphan_high();
    cyc(1'b1, 1'b1, 4'h3);
    tests++; if (ifc.err !== 1'b1) begin $display("FAIL orphan_err got=%b want=1", ifc.err); fails++; end
    tests++; if (ifc.out1 !== 4'h0) begin $display("FAIL orphan_out1 got=%h want=0", ifc.out1); fails++; end
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL orphan_bv got=%b want=0", ifc.byte_valid); fails++; end
    tests++; if (ifc.busy !== 1'b0) begin $display("FAIL orphan_busy got=%b want=0", ifc.busy); fails++; end
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL orphan_err_pulse got=%b want=0", ifc.err); fails++; end
  endtask

  task automatic test_pair();
    cyc(1'b1, 1'b0, 4'hA);
    tests++; if (ifc.busy !== 1'b1) begin $display("FAIL pair_busy_lo got=%b want=1", ifc.busy); fails++; end
    tests++; if (ifc.out0 !== 4'hA) begin $display("FAIL pair_out0 got=%h want=A", ifc.out0); fails++; end
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL pair_bv_early got=%b want=0", ifc.byte_valid); fails++; end
    exp_q.push_back(8'h5A);
    cyc(1'b1, 1'b1, 4'h5);
    tests++; if (ifc.byte_valid !== 1'b1) begin $display("FAIL pair_bv got=%b want=1", ifc.byte_valid); fails++; end
    tests++; if (ifc.byte_out !== 8'h5A) begin $display("FAIL pair_byte got=%h want=5A", ifc.byte_out); fails++; end
    tests++; if (ifc.out1 !== 4'h5) begin $display("FAIL pair_out1 got=%h want=5", ifc.out1); fails++; end
    tests++; if (ifc.busy !== 1'b0) begin $display("FAIL pair_busy_hi got=%b want=0", ifc.busy); fails++; end
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL pair_bv_pulse got=%b want=0", ifc.byte_valid); fails++; end
    tests++; if (ifc.byte_out !== 8'h5A) begin $display("FAIL pair_byte_hold got=%h want=5A", ifc.byte_out); fails++; end
  endtask

  task automatic test_double_low();
    cyc(1'b1, 1'b0, 4'h1);
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL dbl_err_first got=%b want=0", ifc.err); fails++; end
    cyc(1'b1, 1'b0, 4'h2);
    tests++; if (ifc.err !== 1'b1) begin $display("FAIL dbl_err got=%b want=1", ifc.err); fails++; end
    tests++; if (ifc.out0 !== 4'h2) begin $display("FAIL dbl_out0 got=%h want=2", ifc.out0); fails++; end
    tests++; if (ifc.busy !== 1'b1) begin $display("FAIL dbl_busy got=%b want=1", ifc.busy); fails++; end
    exp_q.push_back(8'hF2);
    cyc(1'b1, 1'b1, 4'hF);
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL dbl_err_hi got=%b want=0", ifc.err); fails++; end
    tests++; if (ifc.byte_out !== 8'hF2) begin $display("FAIL dbl_byte got=%h want=F2", ifc.byte_out); fails++; end
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_timeout();
    cyc(1'b1, 1'b0, 4'h7);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0, 4'h0);
      tests++; if (ifc.err !== 1'b0 || ifc.busy !== 1'b1) begin
        $display("FAIL to_wait%0d err=%b busy=%b want err=0 busy=1", i, ifc.err, ifc.busy); fails++; end
    end
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (ifc.err !== 1'b1) begin $display("FAIL to_err got=%b want=1", ifc.err); fails++; end
    tests++; if (ifc.busy !== 1'b0) begin $display("FAIL to_busy got=%b want=0", ifc.busy); fails++; end
    tests++; if (ifc.out0 !== 4'h7) begin $display("FAIL to_out0 got=%h want=7", ifc.out0); fails++; end
    cyc(1'b1, 1'b1, 4'h9);
    tests++; if (ifc.err !== 1'b1) begin $display("FAIL to_late_err got=%b want=1", ifc.err); fails++; end
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL to_late_bv got=%b want=0", ifc.byte_valid); fails++; end
    tests++; if (ifc.byte_out !== 8'hF2) begin $display("FAIL to_late_byte got=%h want=F2", ifc.byte_out); fails++; end
    // High nibble lands on the very cycle the timer would expire.
    cyc(1'b1, 1'b0, 4'h6);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0);
    exp_q.push_back(8'h86);
    cyc(1'b1, 1'b1, 4'h8);
    tests++; if (ifc.byte_valid !== 1'b1) begin $display("FAIL to_edge_bv got=%b want=1", ifc.byte_valid); fails++; end
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL to_edge_err got=%b want=0", ifc.err); fails++; end
    tests++; if (ifc.byte_out !== 8'h86) begin $display("FAIL to_edge_byte got=%h want=86", ifc.byte_out); fails++; end
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_back_to_back();
    int bv0;
    int errs;
    logic [3:0] vals[3];
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h3;
    bv0  = bv_count;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, vals[i]);
      if (ifc.err !== 1'b0) errs++;
      exp_q.push_back({vals[i], vals[i]});
      cyc(1'b1, 1'b1, vals[i]);
      if (ifc.err !== 1'b0) errs++;
    end
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (errs != 0) begin $display("FAIL b2b_err got=%0d want=0", errs); fails++; end
    tests++; if (bv_count - bv0 != 3) begin $display("FAIL b2b_pulses got=%0d want=3", bv_count - bv0); fails++; end
  endtask

  task automatic test_reset_mid_pair();
    int bv0;
    bv0 = bv_count;
    cyc(1'b1, 1'b0, 4'h1);
    exp_q.push_back(8'h11);
    cyc(1'b1, 1'b1, 4'h1);
    cyc(1'b1, 1'b0, 4'h2);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 4'h2);
    rst = 1'b0;
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL rmid_err got=%b want=0", ifc.err); fails++; end
    tests++; if (ifc.busy !== 1'b0) begin $display("FAIL rmid_busy got=%b want=0", ifc.busy); fails++; end
    tests++; if (ifc.byte_valid !== 1'b0) begin $display("FAIL rmid_bv got=%b want=0", ifc.byte_valid); fails++; end
    cyc(1'b1, 1'b0, 4'h3);
    exp_q.push_back(8'h33);
    cyc(1'b1, 1'b1, 4'h3);
    tests++; if (ifc.err !== 1'b0) begin $display("FAIL rmid_err2 got=%b want=0", ifc.err); fails++; end
    tests++; if (ifc.byte_out !== 8'h33) begin $display("FAIL rmid_byte got=%h want=33", ifc.byte_out); fails++; end
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (bv_count - bv0 != 2) begin $display("FAIL rmid_pulses got=%0d want=2", bv_count - bv0); fails++; end
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.s        = 1'b0;
    ifc.in       = 4'h0;
    test_reset();
    test_orphan_high();
    test_pair();
    test_double_low();
    test_timeout();
    test_back_to_back();
    test_reset_mid_pair();
    cyc(1'b0, 1'b0, 4'h0);
    tests++; if (exp_q.size() != 0) begin $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); fails++; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
